// File: rtl/casu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : casu_pkg                                                        |
// | Purpose  : Shared types and constants for the CASU ER pointer programmer.  |
// |            Holds the programmer state encoding, the ER_min/ER_max word     |
// |            offsets and the peripheral-bus write-enable codes.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package casu_pkg;

  // Programmer sequence states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHK    = 3'd1,
    ST_WR_MIN = 3'd2,
    ST_WR_MAX = 3'd3,
    ST_RD_MIN = 3'd4,
    ST_RD_MAX = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } casu_ep_state_e;

  // Word offsets of the pointer registers relative to the base word address
  localparam logic [13:0] ERMIN = 14'd0;
  localparam logic [13:0] ERMAX = 14'd1;

  // openMSP430 per_we encodings
  localparam logic [1:0] PER_WE_WR = 2'b11;
  localparam logic [1:0] PER_WE_RD = 2'b00;

endpackage
`default_nettype wire

// File: rtl/casu_ep_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : casu_ep_prog                                                    |
// | Purpose  : Peripheral-bus initiator that programs the CASU ER_min/ER_max   |
// |            pointer pair. On an accepted start it checks min <= max, writes |
// |            ER_min then ER_max and, when readback is built in, reads both   |
// |            back and retries the whole sequence on a mismatch.             |
// | Config   : CASU_EP_PROG_READBACK_EN - adds the RD_MIN/RD_MAX readback and  |
// |            retry logic. Undefined: WR_MAX goes straight to DONE.           |
// | Ports    : mclk, puc_rst (async, active-high)                              |
// |            start, new_min, new_max   - request from the update controller  |
// |            bus_gnt, per_dout         - arbiter grant, peripheral read data |
// |            per_addr/per_din/per_en/per_we - bus outputs, 0 when not driving|
// |            bus_req, busy, done, err  - status to the update controller     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module casu_ep_prog
  import casu_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0140,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned RETRY_WD  = 2
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        start,
  input  logic [15:0] new_min,
  input  logic [15:0] new_max,
  input  logic        bus_gnt,
  input  logic [15:0] per_dout,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  output logic        bus_req,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [13:0] c_addr_min = BASE_ADDR[14:1] + ERMIN;
  localparam logic [13:0] c_addr_max = BASE_ADDR[14:1] + ERMAX;

  casu_ep_state_e r_state;
  casu_ep_state_e w_state_nxt;

  logic [15:0] r_min;
  logic [15:0] r_max;
  logic        w_accept;

  // start is only honoured while idle; a pulse during a sequence is dropped
  assign w_accept = (r_state == ST_IDLE) && start;
  assign busy     = (r_state != ST_IDLE);

`ifdef CASU_EP_PROG_READBACK_EN
  logic [RETRY_WD-1:0] r_retry;
  logic                w_retry_ok;
  logic                w_retry_inc;

  assign w_retry_ok = (r_retry < RETRY_WD'(MAX_RETRY));
`else
  // Readback data and retry configuration have no function in this build
  logic w_unused_cfg;
  assign w_unused_cfg = ^{per_dout, RETRY_WD'(MAX_RETRY)};
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus decode. Bus outputs are a pure function of the state
  // and bus_gnt, so an ungranted bus state drives nothing and simply waits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    per_en      = 1'b0;
    per_we      = PER_WE_RD;
    per_addr    = '0;
    per_din     = '0;
`ifdef CASU_EP_PROG_READBACK_EN
    w_retry_inc = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        w_state_nxt = (r_min > r_max) ? ST_ERR : ST_WR_MIN;
      end
      ST_WR_MIN: begin
        if (bus_gnt) begin
          per_en      = 1'b1;
          per_we      = PER_WE_WR;
          per_addr    = c_addr_min;
          per_din     = r_min;
          w_state_nxt = ST_WR_MAX;
        end
      end
      ST_WR_MAX: begin
        if (bus_gnt) begin
          per_en   = 1'b1;
          per_we   = PER_WE_WR;
          per_addr = c_addr_max;
          per_din  = r_max;
`ifdef CASU_EP_PROG_READBACK_EN
          w_state_nxt = ST_RD_MIN;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef CASU_EP_PROG_READBACK_EN
      // per_dout is combinational, so it is judged at the edge ending the cycle
      ST_RD_MIN: begin
        if (bus_gnt) begin
          per_en   = 1'b1;
          per_addr = c_addr_min;
          if (per_dout == r_min) begin
            w_state_nxt = ST_RD_MAX;
          end else if (w_retry_ok) begin
            w_retry_inc = 1'b1;
            w_state_nxt = ST_WR_MIN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_RD_MAX: begin
        if (bus_gnt) begin
          per_en   = 1'b1;
          per_addr = c_addr_max;
          if (per_dout == r_max) begin
            w_state_nxt = ST_DONE;
          end else if (w_retry_ok) begin
            w_retry_inc = 1'b1;
            w_state_nxt = ST_WR_MIN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Captured request and sticky status. done/err are set from the terminal
  // state, so they rise in the same cycle busy falls.
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_min   <= '0;
      r_max   <= '0;
      bus_req <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_min   <= new_min;
        r_max   <= new_max;
        bus_req <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        done    <= 1'b1;
        bus_req <= 1'b0;
      end
      if (r_state == ST_ERR) begin
        err     <= 1'b1;
        bus_req <= 1'b0;
      end
    end
  end

`ifdef CASU_EP_PROG_READBACK_EN
  // Number of retries already spent on the current request
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_retry <= '0;
    end else if (w_accept) begin
      r_retry <= '0;
    end else if (w_retry_inc) begin
      r_retry <= r_retry + RETRY_WD'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_casu_ep_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_casu_ep_prog                                                 |
// | Purpose  : Self-checking bench for casu_ep_prog. Models the casu_ep_per    |
// |            pointer registers (reset E000/EFFF) with a read-data corruptor, |
// |            keeps a queue of expected bus cycles and checks latency/status. |
// |            Follows CASU_EP_PROG_READBACK_EN like the design.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_casu_ep_prog;

  typedef struct packed {
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } bus_t;

`ifdef CASU_EP_PROG_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif
  localparam logic [13:0] A_MIN = 14'h00A0;
  localparam logic [13:0] A_MAX = 14'h00A1;

  logic        mclk;
  logic        puc_rst;
  logic        start;
  logic [15:0] new_min;
  logic [15:0] new_max;
  logic        bus_gnt;
  logic [15:0] per_dout;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic        bus_req;
  logic        busy;
  logic        done;
  logic        err;

  int   n_vec  = 0;
  int   n_miss = 0;
  bus_t exp_q[$];
  logic stall_req;
  int   corrupt_n;

  casu_ep_prog dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .start    (start),
    .new_min  (new_min),
    .new_max  (new_max),
    .bus_gnt  (bus_gnt),
    .per_dout (per_dout),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .bus_req  (bus_req),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder: ER pointer registers + corruptor -------------
  logic [15:0] rsp_min;
  logic [15:0] rsp_max;
  int          rd_cnt;

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      rsp_min <= 16'hE000;
      rsp_max <= 16'hEFFF;
      rd_cnt  <= 0;
    end else if (per_en) begin
      if (per_we == 2'b11) begin
        if (per_addr == A_MIN) rsp_min <= per_din;
        else if (per_addr == A_MAX) rsp_max <= per_din;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (per_en && per_we == 2'b00) begin
      per_dout = (per_addr == A_MAX) ? rsp_max : rsp_min;
      if (rd_cnt < corrupt_n) per_dout = per_dout ^ 16'h0010;
    end
  end

  // ---------------- bus monitor / scoreboard pop + grant control ------------
  initial begin
    bus_t e;
    bus_gnt = 1'b1;
    forever begin
      @(negedge mclk);
      if (per_en) begin
        if (exp_q.size() == 0) begin
          chk("bus_qlen", 48'(exp_q.size()), 48'd1);
        end else begin
          e = exp_q.pop_front();
          chk("bus_addr", 48'(per_addr), 48'(e.addr));
          chk("bus_we",   48'(per_we),   48'(e.we));
          chk("bus_din",  48'(per_din),  48'(e.din));
        end
        // hold off the grant for three cycles once ER_min has been written
        if (stall_req && per_we == 2'b11 && per_addr == A_MIN) begin
          @(posedge mclk);
          #1 bus_gnt = 1'b0;
          repeat (3) begin
            @(negedge mclk);
            chk("stall_en", 48'(per_en), 48'd0);
            @(posedge mclk);
          end
          #1 bus_gnt = 1'b1;
        end
      end else begin
        chk("idle_bus", 48'({per_we, per_addr, per_din}), 48'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic push_bus(input logic [13:0] a, input logic [1:0] we, input logic [15:0] d);
    exp_q.push_back({a, we, d});
  endtask

  // one attempt: both writes, then 'reads' readback cycles
  task automatic push_try(input logic [15:0] mn, input logic [15:0] mx, input int reads);
    push_bus(A_MIN, 2'b11, mn);
    push_bus(A_MAX, 2'b11, mx);
    if (reads >= 1) push_bus(A_MIN, 2'b00, 16'h0000);
    if (reads >= 2) push_bus(A_MAX, 2'b00, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    puc_rst = 1'b1;
    @(negedge mclk);
    puc_rst = 1'b0;
    exp_q.delete();
  endtask

  // start -> CHK -> queued bus cycles (+stall) -> terminal state -> flag
  task automatic run(input logic [15:0] mn, input logic [15:0] mx, input int stall,
                     input logic exp_done, input logic rebump);
    int n;
    int exp_n;
    exp_n = 3 + exp_q.size() + stall;
    @(negedge mclk);
    new_min = mn;
    new_max = mx;
    start   = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    n     = 1;
    chk("busy_acc",  48'(busy),       48'd1);
    chk("breq_acc",  48'(bus_req),    48'd1);
    chk("flags_clr", 48'({done, err}), 48'd0);
    if (rebump) begin
      new_min = 16'h5555;
      new_max = 16'h1234;
      start   = 1'b1;
      @(negedge mclk);
      start = 1'b0;
      n     = 2;
    end
    while (!(done || err) && n < 60) begin
      @(negedge mclk);
      n++;
    end
    chk("latency",  48'(n),        48'(exp_n));
    chk("done",     48'(done),     48'(exp_done));
    chk("err",      48'(err),      48'(!exp_done));
    chk("busy_end", 48'(busy),     48'd0);
    chk("breq_end", 48'(bus_req),  48'd0);
    chk("q_empty",  48'(exp_q.size()), 48'd0);
    @(negedge mclk);
    chk("sticky",   48'({done, err}), exp_done ? 48'd2 : 48'd1);
  endtask

  task automatic chk_rsp(input logic [15:0] mn, input logic [15:0] mx);
    chk("rsp_min", 48'(rsp_min), 48'(mn));
    chk("rsp_max", 48'(rsp_max), 48'(mx));
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    start     = 1'b0;
    new_min   = 16'h0000;
    new_max   = 16'h0000;
    stall_req = 1'b0;
    corrupt_n = 0;
    puc_rst   = 1'b1;
    repeat (2) @(negedge mclk);
    chk("rst_bus",   48'({per_en, per_we, per_addr, per_din}), 48'd0);
    chk("rst_flags", 48'({bus_req, busy, done, err}), 48'd0);
    puc_rst = 1'b0;

    // nominal programming
    push_try(16'hE100, 16'hE1FF, RB);
    run(16'hE100, 16'hE1FF, 0, 1'b1, 1'b0);
    chk_rsp(16'hE100, 16'hE1FF);

    // inverted region: no bus cycles, registers untouched
    do_reset();
    run(16'hE200, 16'hE100, 0, 1'b0, 1'b0);
    chk_rsp(16'hE000, 16'hEFFF);

    // one-above boundary also rejected
    run(16'h8001, 16'h8000, 0, 1'b0, 1'b0);

    // min == max accepted
    push_try(16'h8000, 16'h8000, RB);
    run(16'h8000, 16'h8000, 0, 1'b1, 1'b0);
    chk_rsp(16'h8000, 16'h8000);

    // full range
    push_try(16'h0000, 16'hFFFF, RB);
    run(16'h0000, 16'hFFFF, 0, 1'b1, 1'b0);
    chk_rsp(16'h0000, 16'hFFFF);

    // grant withheld for three cycles in WR_MAX
    stall_req = 1'b1;
    push_try(16'h1111, 16'h2222, RB);
    run(16'h1111, 16'h2222, 3, 1'b1, 1'b0);
    stall_req = 1'b0;
    chk_rsp(16'h1111, 16'h2222);

    // second start while busy is ignored
    push_try(16'hE300, 16'hE3FF, RB);
    run(16'hE300, 16'hE3FF, 0, 1'b1, 1'b1);
    chk_rsp(16'hE300, 16'hE3FF);

`ifdef CASU_EP_PROG_READBACK_EN
    // first ER_min readback corrupted: one retry then success
    do_reset();
    corrupt_n = 1;
    push_try(16'hE400, 16'hE4FF, 1);
    push_try(16'hE400, 16'hE4FF, 2);
    run(16'hE400, 16'hE4FF, 0, 1'b1, 1'b0);
    chk_rsp(16'hE400, 16'hE4FF);

    // every readback corrupted: three attempts then err
    do_reset();
    corrupt_n = 1000;
    repeat (3) push_try(16'hE500, 16'hE5FF, 1);
    run(16'hE500, 16'hE5FF, 0, 1'b0, 1'b0);
    corrupt_n = 0;
`endif

    // reset in the middle of a sequence (RD_MIN, or WR_MAX without readback)
    do_reset();
    push_try(16'hE600, 16'hE6FF, RB);
    @(negedge mclk);
    new_min = 16'hE600;
    new_max = 16'hE6FF;
    start   = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (RB > 0 ? 3 : 2) @(negedge mclk);
    chk("pre_rst_en",   48'(per_en),   48'd1);
    chk("pre_rst_addr", 48'(per_addr), RB > 0 ? 48'(A_MIN) : 48'(A_MAX));
    puc_rst = 1'b1;
    @(negedge mclk);
    chk("mid_rst_bus",   48'({per_en, per_we, per_addr, per_din}), 48'd0);
    chk("mid_rst_flags", 48'({bus_req, busy, done, err}), 48'd0);
    puc_rst = 1'b0;
    exp_q.delete();
    @(negedge mclk);
    chk("post_rst_busy", 48'(busy), 48'd0);

    push_try(16'hE700, 16'hE7FF, RB);
    run(16'hE700, 16'hE7FF, 0, 1'b1, 1'b0);
    chk_rsp(16'hE700, 16'hE7FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
